video_bbox_detect: RTL and testbench
====================================

VIDEO_BBOX_DETECT -- requirements
Module: video_bbox_detect

Interface
REQ-001 SHALL have parameter IMAGE_W, default 640, active pixels per line.
REQ-002 SHALL have parameter IMAGE_H, default 480, active lines per frame.
REQ-003 SHALL have parameters R_MIN 160, G_MAX 80, B_MAX 80, the colour-match thresholds (8-bit each).
REQ-004 SHALL have parameter MIN_PIXELS, default 16, the minimum matched-pixel count for a valid detection.
REQ-005 SHALL have ports, one per line:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- sink_data  in  24  Avalon-ST video {R[23:16],G[15:8],B[7:0]}
- sink_valid / sink_startofpacket / sink_endofpacket  in  1 each
- sink_ready  out  1
- source_data  out  24
- source_valid / source_startofpacket / source_endofpacket  out  1 each
- source_ready  in  1
- mode  in  1  overlay enable
- bbox_left / bbox_right  out  11  column bounds, inclusive
- bbox_top / bbox_bottom  out  10  row bounds, inclusive
- bbox_found  out  1  last completed frame met MIN_PIXELS
- bbox_valid  out  1  one-cycle pulse when bbox_* are updated

Function
REQ-006 SHALL use a single output register stage; sink_ready = source_ready OR NOT source_valid; a beat transfers on the sink when sink_valid AND sink_ready.
REQ-007 SHALL copy accepted sop/eop to source and hold all source_* stable while source_valid=1 and source_ready=0; latency is exactly 1 cycle from sink acceptance to source_valid.
REQ-008 SHALL implement FSM IDLE, VIDEO, OTHER.
- IDLE: on accepted SOP beat with data[3:0]=0 go VIDEO; on an SOP beat with any other value go OTHER; drop non-SOP beats (no output).
- VIDEO/OTHER: on accepted EOP go IDLE.
- An accepted SOP in VIDEO/OTHER restarts per REQ-008 IDLE rules; the current frame's statistics are discarded and never published.
REQ-009 SHALL pass header beats and all OTHER-packet beats through unmodified.
REQ-010 SHALL hold x (11b) and y (10b) at 0 on a video SOP; after each accepted VIDEO pixel beat x increments; at x=IMAGE_W-1, x wraps to 0 and y increments; y saturates at IMAGE_H.
REQ-011 SHALL flag a pixel as matched when R>=R_MIN AND G<=G_MAX AND B<=B_MAX AND y<IMAGE_H.
REQ-012 SHALL maintain per-frame running min_x, max_x, min_y, max_y and a 20-bit saturating match count, initialised on video SOP to min=all-ones, max=0, count=0.
REQ-013 SHALL, on accepted EOP in VIDEO, on the next cycle load bbox_* from running values, set bbox_found = (count>=MIN_PIXELS), and pulse bbox_valid high for exactly 1 cycle; bbox_* are updated only when bbox_found is 1 and otherwise hold their previous values.
REQ-014 SHALL, when mode=1 and bbox_found=1, replace the output of a VIDEO pixel at (x,y) with 24'h00FF00 if it lies on the rectangle edge (x equals left or right with top<=y<=bottom, or y equals top or bottom with left<=x<=right) of the previously published box; otherwise output sink_data unchanged.
REQ-015 SHALL sample mode at each pixel acceptance; a mid-frame change takes effect from the next pixel.

Reset
REQ-016 SHALL, on reset=1 at a clk edge, force FSM=IDLE, x=y=0, source_valid/sop/eop=0, source_data=0, bbox_*=0, bbox_found=0, bbox_valid=0, running stats to their REQ-012 initial values; reset mid-packet discards the packet.
REQ-017 SHALL drive sink_ready=1 during reset.

Verification
REQ-018 SHALL cover a 640x480 frame with a red 10x10 block at (100,50), mode=0 -> bbox_valid pulse 1 cycle after EOP, left=100, right=109, top=50, bottom=59, found=1, pixels unmodified.
REQ-019 SHALL cover a frame with 15 matched pixels -> found=0 and bbox_* retain their prior values.
REQ-020 SHALL cover a second frame with mode=1 -> pixel (100,55) and pixel (105,50) output 00FF00, pixel (105,55) passes through.
REQ-021 SHALL cover random source_ready backpressure at 50% -> the output stream is bit-identical to the no-stall run with no lost or duplicated beats.
REQ-022 SHALL cover a control packet (header 0xF) followed by a new video SOP in mid-frame -> control beats pass through unmodified, no bbox_valid pulse occurs for the aborted frame, and the new frame's stats are correct.
REQ-023 SHALL cover reset asserted mid-frame -> all outputs are 0 the next cycle, and the following full frame produces a correct box.

Source files
------------

// File: rtl/video_bbox_detect.sv
// Red-object bounding-box detector on an Avalon-ST video stream with one output
// register stage and optional green rectangle overlay of the last published box.
module video_bbox_detect #(
  parameter int         IMAGE_W    = 640,
  parameter int         IMAGE_H    = 480,
  parameter logic [7:0] R_MIN      = 8'd160,
  parameter logic [7:0] G_MAX      = 8'd80,
  parameter logic [7:0] B_MAX      = 8'd80,
  parameter int         MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_startofpacket,
  input  logic        sink_endofpacket,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_startofpacket,
  output logic        source_endofpacket,
  input  logic        source_ready,
  input  logic        mode,
  output logic [10:0] bbox_left,
  output logic [10:0] bbox_right,
  output logic [9:0]  bbox_top,
  output logic [9:0]  bbox_bottom,
  output logic        bbox_found,
  output logic        bbox_valid
);

  localparam logic [10:0] LP_X_LAST  = 11'(IMAGE_W - 1);
  localparam logic [9:0]  LP_Y_END   = 10'(IMAGE_H);
  localparam logic [19:0] LP_MIN_CNT = 20'(MIN_PIXELS);
  localparam logic [19:0] LP_CNT_SAT = 20'hFFFFF;
  localparam logic [23:0] LP_GREEN   = 24'h00FF00;

  typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_OTHER} state_t;

  state_t      r_state, w_state_nxt;
  logic [10:0] r_x, w_x_nxt;
  logic [9:0]  r_y, w_y_nxt;
  logic [10:0] r_min_x, r_max_x, w_min_x, w_max_x;
  logic [9:0]  r_min_y, r_max_y, w_min_y, w_max_y;
  logic [19:0] r_cnt, w_cnt;

  logic [23:0] r_src_data;
  logic        r_src_valid, r_src_sop, r_src_eop;
  logic [10:0] r_bb_l, r_bb_r;
  logic [9:0]  r_bb_t, r_bb_b;
  logic        r_bb_found, r_bb_valid;

  logic        w_sink_ready, w_accept;
  logic        w_emit, w_pixel, w_vsop, w_publish;
  logic        w_match, w_on_edge;
  logic [23:0] w_out_data;

  // Reset term keeps the sink open while the block is being cleared.
  assign w_sink_ready = reset | source_ready | ~r_src_valid;
  assign w_accept     = sink_valid & w_sink_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_pixel     = 1'b0;
    w_vsop      = 1'b0;
    w_publish   = 1'b0;
    if (w_accept) begin
      if (sink_startofpacket) begin
        w_emit      = 1'b1;
        w_vsop      = (sink_data[3:0] == 4'h0);
        if (sink_endofpacket)
          w_state_nxt = S_IDLE;
        else
          w_state_nxt = (sink_data[3:0] == 4'h0) ? S_VIDEO : S_OTHER;
      end else begin
        unique case (r_state)
          S_VIDEO: begin
            w_emit  = 1'b1;
            w_pixel = 1'b1;
            if (sink_endofpacket) begin
              w_publish   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_OTHER: begin
            w_emit = 1'b1;
            if (sink_endofpacket) w_state_nxt = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_match = w_pixel
                 & (sink_data[23:16] >= R_MIN)
                 & (sink_data[15:8]  <= G_MAX)
                 & (sink_data[7:0]   <= B_MAX)
                 & (r_y < LP_Y_END);

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_vsop) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (w_pixel) begin
      if (r_x == LP_X_LAST) begin
        w_x_nxt = '0;
        if (r_y != LP_Y_END) w_y_nxt = r_y + 10'd1;
      end else begin
        w_x_nxt = r_x + 11'd1;
      end
    end
  end

  // Stats including the current beat, so an EOP pixel lands in the published box.
  always_comb begin
    w_min_x = r_min_x;
    w_max_x = r_max_x;
    w_min_y = r_min_y;
    w_max_y = r_max_y;
    w_cnt   = r_cnt;
    if (w_match) begin
      if (r_x < r_min_x) w_min_x = r_x;
      if (r_x > r_max_x) w_max_x = r_x;
      if (r_y < r_min_y) w_min_y = r_y;
      if (r_y > r_max_y) w_max_y = r_y;
      if (r_cnt != LP_CNT_SAT) w_cnt = r_cnt + 20'd1;
    end
  end

  assign w_on_edge = (((r_x == r_bb_l) || (r_x == r_bb_r)) && (r_y >= r_bb_t) && (r_y <= r_bb_b))
                  || (((r_y == r_bb_t) || (r_y == r_bb_b)) && (r_x >= r_bb_l) && (r_x <= r_bb_r));

  assign w_out_data = (w_pixel && mode && r_bb_found && w_on_edge) ? LP_GREEN : sink_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_min_x     <= '1;
      r_max_x     <= '0;
      r_min_y     <= '1;
      r_max_y     <= '0;
      r_cnt       <= '0;
      r_src_data  <= '0;
      r_src_valid <= 1'b0;
      r_src_sop   <= 1'b0;
      r_src_eop   <= 1'b0;
      r_bb_l      <= '0;
      r_bb_r      <= '0;
      r_bb_t      <= '0;
      r_bb_b      <= '0;
      r_bb_found  <= 1'b0;
      r_bb_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      if (w_vsop) begin
        r_min_x <= '1;
        r_max_x <= '0;
        r_min_y <= '1;
        r_max_y <= '0;
        r_cnt   <= '0;
      end else begin
        r_min_x <= w_min_x;
        r_max_x <= w_max_x;
        r_min_y <= w_min_y;
        r_max_y <= w_max_y;
        r_cnt   <= w_cnt;
      end

      r_bb_valid <= w_publish;
      if (w_publish) begin
        r_bb_found <= (w_cnt >= LP_MIN_CNT);
        if (w_cnt >= LP_MIN_CNT) begin
          r_bb_l <= w_min_x;
          r_bb_r <= w_max_x;
          r_bb_t <= w_min_y;
          r_bb_b <= w_max_y;
        end
      end

      if (w_accept) begin
        r_src_valid <= w_emit;
        if (w_emit) begin
          r_src_data <= w_out_data;
          r_src_sop  <= sink_startofpacket;
          r_src_eop  <= sink_endofpacket;
        end
      end else if (source_ready) begin
        r_src_valid <= 1'b0;
      end
    end
  end

  assign sink_ready           = w_sink_ready;
  assign source_data          = r_src_data;
  assign source_valid         = r_src_valid;
  assign source_startofpacket = r_src_sop;
  assign source_endofpacket   = r_src_eop;
  assign bbox_left            = r_bb_l;
  assign bbox_right           = r_bb_r;
  assign bbox_top             = r_bb_t;
  assign bbox_bottom          = r_bb_b;
  assign bbox_found           = r_bb_found;
  assign bbox_valid           = r_bb_valid;

endmodule

// File: tb/tb_video_bbox_detect.sv
// Bench for video_bbox_detect: frame-level reference model, per-beat scoreboard,
// bbox event checks and literal pins on the published boxes.
module tb_video_bbox_detect;
  localparam int W    = 112;
  localparam int H    = 62;
  localparam int MINP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0, sink_startofpacket = 1'b0, sink_endofpacket = 1'b0;
  logic        sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_startofpacket, source_endofpacket;
  logic        source_ready = 1'b1;
  logic        mode = 1'b0;
  logic [10:0] bbox_left, bbox_right;
  logic [9:0]  bbox_top, bbox_bottom;
  logic        bbox_found, bbox_valid;

  video_bbox_detect #(
    .IMAGE_W(W), .IMAGE_H(H), .R_MIN(8'd160), .G_MAX(8'd80), .B_MAX(8'd80), .MIN_PIXELS(MINP)
  ) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_startofpacket(sink_startofpacket), .sink_endofpacket(sink_endofpacket),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid),
    .source_startofpacket(source_startofpacket), .source_endofpacket(source_endofpacket),
    .source_ready(source_ready), .mode(mode),
    .bbox_left(bbox_left), .bbox_right(bbox_right), .bbox_top(bbox_top), .bbox_bottom(bbox_bottom),
    .bbox_found(bbox_found), .bbox_valid(bbox_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        f;
    logic [10:0] l, r;
    logic [9:0]  t, b;
  } box_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pub_cyc = -10;

  logic [25:0] exp_q[$];
  box_t        ev_q[$];
  box_t        mbox = '0;
  int          mq_x[$], mq_y[$];
  int          blk_l, blk_t, blk_w, blk_h;
  bit          stall_en = 1'b0;
  logic        rdy_fix = 1'b1;

  logic [23:0] obs[W*H];
  logic [23:0] obs_ref[W*H];
  int          oidx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    source_ready <= stall_en ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] pixel(input int x, input int y);
    if (x >= blk_l && x < blk_l + blk_w && y >= blk_t && y < blk_t + blk_h) begin
      if (x == blk_l && y == blk_t) return 24'hA05050;   // exactly on all three thresholds
      return {8'd200, 8'(y % 64), 8'(x % 50)};
    end
    if (y == 0 && x == 0) return 24'h9F0000;             // R one below threshold
    if (y == 0 && x == 1) return 24'hFF5100;             // G one above
    if (y == 0 && x == 2) return 24'hFF0051;             // B one above
    return {8'((x + y) & 127), 8'(y), 8'(x)};
  endfunction

  function automatic bit is_match(input logic [23:0] d, input int y);
    return d[23:16] >= 8'd160 && d[15:8] <= 8'd80 && d[7:0] <= 8'd80 && y < H;
  endfunction

  function automatic bit on_edge(input int x, input int y, input box_t b);
    int l, r, t, bt;
    l = int'(b.l); r = int'(b.r); t = int'(b.t); bt = int'(b.b);
    return ((x == l || x == r) && y >= t && y <= bt) || ((y == t || y == bt) && x >= l && x <= r);
  endfunction

  task automatic publish();
    int lo_x, hi_x, lo_y, hi_y;
    if (mq_x.size() >= MINP) begin
      lo_x = mq_x[0]; hi_x = mq_x[0]; lo_y = mq_y[0]; hi_y = mq_y[0];
      foreach (mq_x[k]) begin
        if (mq_x[k] < lo_x) lo_x = mq_x[k];
        if (mq_x[k] > hi_x) hi_x = mq_x[k];
        if (mq_y[k] < lo_y) lo_y = mq_y[k];
        if (mq_y[k] > hi_y) hi_y = mq_y[k];
      end
      mbox = '{f: 1'b1, l: 11'(lo_x), r: 11'(hi_x), t: 10'(lo_y), b: 10'(hi_y)};
    end else begin
      mbox.f = 1'b0;
    end
    ev_q.push_back(mbox);
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [23:0] d, input bit s, input bit e, output int acc);
    int n;
    n = 0;
    sink_data = d; sink_startofpacket = s; sink_endofpacket = e; sink_valid = 1'b1;
    @(negedge clk);
    while (!sink_ready) begin
      n++;
      if (n > 2000) begin
        $display("FAIL sink_ready_timeout: no acceptance after %0d cycles", n);
        $fatal(1, "stuck");
      end
      @(negedge clk);
    end
    acc = cyc;
    @(posedge clk);
    #1;
    sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
  endtask

  task automatic video_frame(input int npix, input bit fin, input int extra);
    int acc, x, y, nb;
    bit last;
    logic [23:0] d, o;
    mq_x.delete(); mq_y.delete();
    exp_q.push_back({1'b1, 1'b0, 24'h5A5A50});
    send_beat(24'h5A5A50, 1'b1, 1'b0, acc);
    nb = npix + extra;
    for (int i = 0; i < nb; i++) begin
      x = i % W;
      y = (i / W < H) ? i / W : H;
      last = fin && (i == nb - 1);
      d = (i < npix) ? pixel(x, y) : 24'hFF0000;
      o = (mode && mbox.f && on_edge(x, y, mbox)) ? 24'h00FF00 : d;
      if (is_match(d, y)) begin mq_x.push_back(x); mq_y.push_back(y); end
      if (last) publish();
      exp_q.push_back({1'b0, last, o});
      send_beat(d, 1'b0, last, acc);
      if (last) pub_cyc = acc;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 5000)) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) fail("drain_timeout");
    repeat (3) @(negedge clk);
    chk("bbox_event_pending", ev_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_box(input string tag, input int f, input int l, input int r, input int t, input int b);
    chk({tag, "_found"}, bbox_found, f);
    chk({tag, "_left"}, bbox_left, l);
    chk({tag, "_right"}, bbox_right, r);
    chk({tag, "_top"}, bbox_top, t);
    chk({tag, "_bottom"}, bbox_bottom, b);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_src"}, {source_valid, source_startofpacket, source_endofpacket, source_data}, 0);
    chk({tag, "_bbox"}, {bbox_left, bbox_right, bbox_top, bbox_bottom, bbox_found, bbox_valid}, 0);
  endtask

  // ---------------- compare process ----------------
  logic        prev_hold = 1'b0, prev_bv = 1'b0;
  logic [25:0] prev_beat;
  logic [25:0] e;
  box_t        eb;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
      prev_bv   = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", {source_valid, source_startofpacket, source_endofpacket, source_data},
                         {1'b1, prev_beat});
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", {source_startofpacket, source_endofpacket, source_data}, e);
        end
        if (source_startofpacket) oidx = 0;
        else begin
          if (oidx < W * H) obs[oidx] = source_data;
          oidx++;
        end
      end
      prev_hold = source_valid && !source_ready;
      prev_beat = {source_startofpacket, source_endofpacket, source_data};
      if (bbox_valid) begin
        chk("bbox_pulse_width", prev_bv, 0);
        chk("bbox_pulse_time", cyc, pub_cyc + 1);
        if (ev_q.size() == 0) fail("unexpected_bbox_valid");
        else begin
          eb = ev_q.pop_front();
          chk("bbox_event", {bbox_found, bbox_left, bbox_right, bbox_top, bbox_bottom}, eb);
        end
      end
      prev_bv = bbox_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_sink_ready", sink_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // stray non-SOP beats in IDLE are swallowed
    send_beat(24'h123456, 1'b0, 1'b0, acc);
    send_beat(24'h654321, 1'b0, 1'b1, acc);

    // F1: 10x10 block at (100,50), no overlay
    blk_l = 100; blk_t = 50; blk_w = 10; blk_h = 10;
    mode = 1'b0;
    video_frame(W * H, 1'b1, 0);
    drain();
    chk_box("f1", 1, 100, 109, 50, 59);
    chk("f1_corner_unmodified", obs[50 * W + 100], 24'hA05050);

    // F2: same scene with overlay of F1's box
    mode = 1'b1;
    video_frame(W * H, 1'b1, 0);
    drain();
    chk("f2_left_edge", obs[55 * W + 100], 24'h00FF00);
    chk("f2_top_edge", obs[50 * W + 105], 24'h00FF00);
    chk("f2_interior", obs[55 * W + 105], 24'hC83705);
    obs_ref = obs;

    // F3: identical frame under 50% backpressure
    stall_en = 1'b1;
    video_frame(W * H, 1'b1, 0);
    drain();
    stall_en = 1'b0;
    chk("stall_identical", obs == obs_ref, 1);
    chk("stall_beat_count", oidx, W * H);

    // F5: video aborted by control packet, partial video aborted by new SOP, then full frame
    blk_l = 20; blk_t = 5; blk_w = 5; blk_h = 4;
    video_frame(3 * W, 1'b0, 0);
    exp_q.push_back({1'b1, 1'b0, 24'h00000F}); send_beat(24'h00000F, 1'b1, 1'b0, acc);
    exp_q.push_back({1'b0, 1'b0, 24'hFF0000}); send_beat(24'hFF0000, 1'b0, 1'b0, acc);
    exp_q.push_back({1'b0, 1'b0, 24'hABCDEF}); send_beat(24'hABCDEF, 1'b0, 1'b0, acc);
    exp_q.push_back({1'b0, 1'b1, 24'hFF0000}); send_beat(24'hFF0000, 1'b0, 1'b1, acc);
    video_frame(7 * W, 1'b0, 0);
    video_frame(W * H, 1'b1, 0);
    drain();
    chk_box("f5", 1, 20, 24, 5, 8);

    // F4: 15 matches plus red beats past the last line -> not found, box held
    mode = 1'b0;
    blk_l = 30; blk_t = 10; blk_w = 5; blk_h = 3;
    video_frame(W * H, 1'b1, 5);
    drain();
    chk_box("f4", 0, 20, 24, 5, 8);

    // reset mid-frame with the output stalled
    blk_l = 100; blk_t = 50; blk_w = 10; blk_h = 10;
    video_frame(55 * W, 1'b0, 0);
    rdy_fix = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_sink_ready", sink_ready, 1);
    @(negedge clk);
    chk_zero("midrst");
    exp_q.delete();
    mbox = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_fix = 1'b1;

    // F7: exactly MIN_PIXELS matches after reset
    blk_l = 60; blk_t = 30; blk_w = 8; blk_h = 2;
    video_frame(W * H, 1'b1, 0);
    drain();
    chk_box("f7", 1, 60, 67, 30, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
